// File: rtl/key_sequence_lock.sv
// Key-driven code lock: a SEQ_LEN-step code entered on KEY[3:0], with inactivity timeout,
// failure counting and timed lockout. HEX0 shows the state, or the entry progress digit.
module key_sequence_lock #(
   parameter int                   SEQ_LEN        = 4,
   parameter logic [2*SEQ_LEN-1:0] CODE           = 8'b11_10_01_00,
   parameter int                   TIMEOUT_CYCLES = 50_000_000,
   parameter int                   MAX_FAIL       = 3,
   parameter int                   LOCKOUT_CYCLES = 250_000_000
) (
   input  logic                            CLOCK_50,
   input  logic                            reset,
   input  logic [3:0]                      KEY,
   output logic [6:0]                      HEX0,
   output logic                            unlocked,
   output logic                            locked_out,
   output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count
);

   localparam int FW  = $clog2(MAX_FAIL + 1);
   localparam int LIM = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
   localparam int TW  = $clog2(LIM);

   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] LO_LAST   = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [FW-1:0] FAIL_LIM  = FW'(MAX_FAIL);
   localparam logic [2:0]    LAST_IDX  = 3'(SEQ_LEN - 1);
   localparam logic [15:0]   CODE_PAD  = 16'(CODE);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ENTRY   = 2'b01,
      OPEN    = 2'b10,
      LOCKOUT = 2'b11
   } state_t;

   state_t          state_r, state_s;
   logic [2:0]      idx_r, idx_s;
   logic [FW-1:0]   fail_r, fail_s, fail_inc_s;
   logic [TW-1:0]   timer_r, timer_s;
   logic [3:0]      sync1_r, sync2_r, prev_r;
   logic [3:0]      press_s;
   logic [1:0]      exp_key_s;
   logic            correct_s, wrong_s;

   function automatic logic [6:0] glyph(input state_t st, input logic [2:0] idx);
      logic [6:0] g;
      case (st)
         IDLE:    g = 7'b0111111;
         OPEN:    g = 7'b1000001;
         LOCKOUT: g = 7'b1000111;
         ENTRY: begin
            case (idx)
               3'd1:    g = 7'b1111001;
               3'd2:    g = 7'b0100100;
               3'd3:    g = 7'b0110000;
               3'd4:    g = 7'b0011001;
               3'd5:    g = 7'b0010010;
               3'd6:    g = 7'b0000010;
               3'd7:    g = 7'b1111000;
               default: g = 7'b0111111;
            endcase
         end
         default: g = 7'b0111111;
      endcase
      return g;
   endfunction

   // Key synchroniser and previous-sample stage; reset high so a key held through reset is not a press
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1_r <= 4'b1111;
         sync2_r <= 4'b1111;
         prev_r  <= 4'b1111;
      end else begin
         sync1_r <= KEY;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Press decode: the press must be exactly the expected key, anything else non-zero is wrong
   always_comb begin
      press_s    = sync2_r & ~prev_r;
      exp_key_s  = CODE_PAD[{idx_r, 1'b0} +: 2];
      correct_s  = (press_s == (4'b0001 << exp_key_s));
      wrong_s    = (press_s != 4'b0000) && !correct_s;
      fail_inc_s = fail_r + FW'(1);
   end

   // Next-state, step index, failure count and shared timer
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      fail_s  = fail_r;
      timer_s = timer_r + TW'(1);
      case (state_r)
         IDLE, ENTRY: begin
            if (correct_s) begin
               timer_s = {TW{1'b0}};
               if (idx_r == LAST_IDX) begin
                  state_s = OPEN;
                  idx_s   = 3'd0;
                  fail_s  = {FW{1'b0}};
               end else begin
                  state_s = ENTRY;
                  idx_s   = idx_r + 3'd1;
               end
            end else if (wrong_s) begin
               idx_s   = 3'd0;
               fail_s  = fail_inc_s;
               state_s = (fail_inc_s == FAIL_LIM) ? LOCKOUT : IDLE;
            end else if (state_r == ENTRY && timer_r == TO_LAST) begin
               state_s = IDLE;
               idx_s   = 3'd0;
            end else begin
               state_s = state_r;
            end
         end
         OPEN: begin
            if (press_s != 4'b0000 || timer_r == TO_LAST) begin
               state_s = IDLE;
            end else begin
               state_s = OPEN;
            end
         end
         LOCKOUT: begin
            // Presses are ignored here, so they do not extend the lockout
            if (timer_r == LO_LAST) begin
               state_s = IDLE;
               fail_s  = {FW{1'b0}};
            end else begin
               state_s = LOCKOUT;
            end
         end
         default: begin
            state_s = IDLE;
            idx_s   = 3'd0;
         end
      endcase
      if (state_s != state_r || state_s == IDLE) begin
         timer_s = {TW{1'b0}};
      end else begin
         timer_s = timer_s;
      end
   end

   // State registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_r <= IDLE;
         idx_r   <= 3'd0;
         fail_r  <= {FW{1'b0}};
         timer_r <= {TW{1'b0}};
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         fail_r  <= fail_s;
         timer_r <= timer_s;
      end
   end

   // Output decode straight from the state registers
   always_comb begin
      HEX0       = glyph(state_r, idx_r);
      unlocked   = (state_r == OPEN);
      locked_out = (state_r == LOCKOUT);
      fail_count = fail_r;
   end

endmodule

// File: tb/tb_key_sequence_lock.sv
// Scoreboard bench for key_sequence_lock: stimulus queues expected outputs for a given cycle,
// a negedge monitor compares them against the DUT.
module tb_key_sequence_lock;

   logic       CLOCK_50;
   logic       reset;
   logic [3:0] KEY;
   logic [6:0] HEX0;
   logic       unlocked;
   logic       locked_out;
   logic [1:0] fail_count;

   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] D1   = 7'b1111001;
   localparam logic [6:0] D2   = 7'b0100100;
   localparam logic [6:0] D3   = 7'b0110000;
   localparam logic [6:0] GU   = 7'b1000001;
   localparam logic [6:0] GL   = 7'b1000111;

   key_sequence_lock #(
      .SEQ_LEN        (4),
      .CODE           (8'b11_10_01_00),
      .TIMEOUT_CYCLES (20),
      .MAX_FAIL       (3),
      .LOCKOUT_CYCLES (40)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .KEY        (KEY),
      .HEX0       (HEX0),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .fail_count (fail_count)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [6:0] hex;
      logic       un;
      logic       lo;
      logic [1:0] fc;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Monitor: compare every queued expectation due at this cycle
   always @(negedge CLOCK_50) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            checks++;
            if (HEX0 !== sb[i].hex || unlocked !== sb[i].un ||
                locked_out !== sb[i].lo || fail_count !== sb[i].fc) begin
               errors++;
               $display("FAIL %s @cyc %0d: got hex=%b unl=%b lo=%b fc=%0d, expected hex=%b unl=%b lo=%b fc=%0d",
                        sb[i].name, cyc, HEX0, unlocked, locked_out, fail_count,
                        sb[i].hex, sb[i].un, sb[i].lo, sb[i].fc);
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic expect_at(input int c, input string n, input logic [6:0] h,
                            input logic u, input logic l, input logic [1:0] f);
      exp_t e;
      e.cyc = c; e.name = n; e.hex = h; e.un = u; e.lo = l; e.fc = f;
      sb.push_back(e);
   endtask

   task automatic press(input logic [3:0] m);
      KEY = m;
      tick(); tick();
      KEY = 4'b0000;
      tick(); tick();
   endtask

   task automatic pulse_reset();
      expect_at(cyc + 1, "reset_vals", DASH, 1'b0, 1'b0, 2'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic fail_pair(input int f, input string n);
      int c;
      c = cyc;
      expect_at(c + 3, {n, "_step0"}, D1, 1'b0, 1'b0, 2'(f - 1));
      press(4'b0001);
      c = cyc;
      if (f == 3) expect_at(c + 3, {n, "_lock"}, GL, 1'b0, 1'b1, 2'd3);
      else        expect_at(c + 3, {n, "_fail"}, DASH, 1'b0, 1'b0, 2'(f));
      press(4'b0100);
   endtask

   initial begin
      int c, c_lo;
      reset = 1'b1;
      KEY   = 4'b0000;
      tick(); tick();
      expect_at(cyc, "reset_state", DASH, 1'b0, 1'b0, 2'd0);
      checks++;
      if (HEX0 !== DASH || unlocked !== 1'b0 || locked_out !== 1'b0 || fail_count !== 2'd0) begin
         errors++;
         $display("FAIL direct_reset: hex=%b unl=%b lo=%b fc=%0d", HEX0, unlocked, locked_out, fail_count);
      end
      tick();
      reset = 1'b0;
      tick();

      // 1: correct code, then relock by any press
      c = cyc; expect_at(c + 3, "t1_k0", D1, 1'b0, 1'b0, 2'd0); press(4'b0001);
      c = cyc; expect_at(c + 3, "t1_k1", D2, 1'b0, 1'b0, 2'd0); press(4'b0010);
      c = cyc; expect_at(c + 3, "t1_k2", D3, 1'b0, 1'b0, 2'd0); press(4'b0100);
      c = cyc;
      expect_at(c + 2, "t1_pre_open", D3, 1'b0, 1'b0, 2'd0);
      expect_at(c + 3, "t1_open", GU, 1'b1, 1'b0, 2'd0);
      press(4'b1000);
      checks++;
      if (HEX0 !== GU || unlocked !== 1'b1 || locked_out !== 1'b0) begin
         errors++;
         $display("FAIL direct_open: hex=%b unl=%b lo=%b", HEX0, unlocked, locked_out);
      end
      c = cyc; expect_at(c + 3, "t1_relock", DASH, 1'b0, 1'b0, 2'd0); press(4'b0010);

      // 2: three failures -> lockout, presses ignored, timed exit
      fail_pair(1, "t2a");
      fail_pair(2, "t2b");
      c_lo = cyc;
      fail_pair(3, "t2c");
      checks++;
      if (HEX0 !== GL || locked_out !== 1'b1 || unlocked !== 1'b0 || fail_count !== 2'd3) begin
         errors++;
         $display("FAIL direct_lockout: hex=%b unl=%b lo=%b fc=%0d", HEX0, unlocked, locked_out, fail_count);
      end
      c_lo = cyc - 4;
      c = cyc; expect_at(c + 3, "t2_ign_a", GL, 1'b0, 1'b1, 2'd3); press(4'b0001);
      c = cyc; expect_at(c + 3, "t2_ign_b", GL, 1'b0, 1'b1, 2'd3); press(4'b0010);
      expect_at(c_lo + 42, "t2_lock_last", GL, 1'b0, 1'b1, 2'd3);
      expect_at(c_lo + 43, "t2_lock_exit", DASH, 1'b0, 1'b0, 2'd0);
      wait_until(c_lo + 44);
      checks++;
      if (HEX0 !== DASH || locked_out !== 1'b0 || fail_count !== 2'd0) begin
         errors++;
         $display("FAIL direct_lock_exit: hex=%b lo=%b fc=%0d", HEX0, locked_out, fail_count);
      end

      // 3: timeout in ENTRY keeps fail_count; a press on the last cycle wins
      fail_pair(1, "t3");
      c = cyc;
      expect_at(c + 3, "t3_k0", D1, 1'b0, 1'b0, 2'd1);
      press(4'b0001);
      expect_at(c + 22, "t3_before_to", D1, 1'b0, 1'b0, 2'd1);
      expect_at(c + 23, "t3_timeout", DASH, 1'b0, 1'b0, 2'd1);
      wait_until(c + 24);
      c = cyc;
      expect_at(c + 3, "t3_k0b", D1, 1'b0, 1'b0, 2'd1);
      press(4'b0001);
      wait_until(c + 20);
      expect_at(c + 22, "t3_last_cycle", D1, 1'b0, 1'b0, 2'd1);
      expect_at(c + 23, "t3_press_wins", D2, 1'b0, 1'b0, 2'd1);
      press(4'b0010);
      expect_at(c + 42, "t3_restarted", D2, 1'b0, 1'b0, 2'd1);
      expect_at(c + 43, "t3_timeout2", DASH, 1'b0, 1'b0, 2'd1);
      wait_until(c + 44);

      // 6: reset in ENTRY idx=3 and in LOCKOUT
      pulse_reset();
      c = cyc; expect_at(c + 3, "t6_k0", D1, 1'b0, 1'b0, 2'd0); press(4'b0001);
      c = cyc; expect_at(c + 3, "t6_k1", D2, 1'b0, 1'b0, 2'd0); press(4'b0010);
      c = cyc; expect_at(c + 3, "t6_k2", D3, 1'b0, 1'b0, 2'd0); press(4'b0100);
      pulse_reset();
      fail_pair(1, "t6a");
      fail_pair(2, "t6b");
      fail_pair(3, "t6c");
      pulse_reset();

      // 4: two keys rising together in IDLE
      c = cyc; expect_at(c + 3, "t4_double", DASH, 1'b0, 1'b0, 2'd1); press(4'b0011);

      // 5: key held across reset release is not a press
      KEY   = 4'b0001;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      c = cyc;
      for (int k = 1; k <= 6; k++) expect_at(c + k, "t5_held", DASH, 1'b0, 1'b0, 2'd0);
      wait_until(c + 7);
      KEY = 4'b0000;
      tick(); tick();
      c = cyc; expect_at(c + 3, "t5_repress", D1, 1'b0, 1'b0, 2'd0); press(4'b0001);
      checks++;
      if (HEX0 !== D1 || unlocked !== 1'b0 || fail_count !== 2'd0) begin
         errors++;
         $display("FAIL direct_repress: hex=%b unl=%b fc=%0d", HEX0, unlocked, fail_count);
      end

      tick(); tick();
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s: never compared, expected at cyc %0d", sb[0].name, sb[0].cyc);
         sb.delete(0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
